// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 set-2 scancode decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2State_e;

    localparam logic [7:0] ByteE0 = 8'hE0;
    localparam logic [7:0] ByteF0 = 8'hF0;
    localparam logic [7:0] ByteE1 = 8'hE1;
    localparam logic [7:0] ByteAA = 8'hAA;
    localparam logic [7:0] ByteFA = 8'hFA;
    localparam logic [7:0] ByteEE = 8'hEE;
    localparam logic [7:0] ByteFE = 8'hFE;

    // Keyboard status/ack bytes that never produce a key event.
    function automatic logic isDropByte(input logic [7:0] b);
        return (b == ByteAA) || (b == ByteFA) || (b == ByteEE) || (b == ByteFE) || (b == 8'h00);
    endfunction

endpackage

// File: rtl/ps2_glitch_filter.sv
// Two-flop synchroniser plus a level filter that only follows the input after
// FILTER consecutive equal samples; reports each filtered 1->0 transition.
module ps2_glitch_filter #(
    parameter int unsigned FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic rawIn,
    output logic level,
    output logic fall
);

    localparam int unsigned CntW = $clog2(FILTER + 1);

    logic [1:0]      syncQ;
    logic [CntW-1:0] cntQ;
    logic            levelQ;
    logic            fallQ;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            syncQ  <= 2'b11;
            cntQ   <= '0;
            levelQ <= 1'b1;
            fallQ  <= 1'b0;
        end else begin
            syncQ <= {syncQ[0], rawIn};
            fallQ <= 1'b0;
            if (syncQ[1] == levelQ) begin
                cntQ <= '0;
            end else if (cntQ == CntW'(FILTER - 1)) begin
                levelQ <= syncQ[1];
                cntQ   <= '0;
                fallQ  <= levelQ;
            end else begin
                cntQ <= cntQ + CntW'(1);
            end
        end
    end

    assign level = levelQ;
    assign fall  = fallQ;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: frames 11-bit serial bytes and folds E0/F0/E1
// prefixes into single key events with press/release and extended flags.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 4200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       strb,
    output logic       make,
    output logic       ext,
    output logic [7:0] code,
    output logic       err
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    logic       ckLevel;
    logic       ckFall;
    logic [1:0] dSyncQ;
    logic       dSync;

    ps2_glitch_filter #(
        .FILTER (FILTER)
    ) uCkFilter (
        .clock (clock),
        .reset (reset),
        .rawIn (ps2Ck),
        .level (ckLevel),
        .fall  (ckFall)
    );

    assign dSync = dSyncQ[1];

    ps2State_e      stateQ, stateD;
    logic [2:0]     bitCntQ, bitCntD;
    logic [7:0]     shiftQ, shiftD;
    logic           parQ, parD;
    logic [WdW-1:0] wdogQ, wdogD;
    logic           extFlagQ, extFlagD;
    logic           brkFlagQ, brkFlagD;
    logic [2:0]     skipQ, skipD;
    logic           strbQ, strbD;
    logic           errQ, errD;
    logic           makeQ, makeD;
    logic           extQ, extD;
    logic [7:0]     codeQ, codeD;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dSyncQ   <= 2'b11;
            stateQ   <= StIdle;
            bitCntQ  <= '0;
            shiftQ   <= '0;
            parQ     <= 1'b0;
            wdogQ    <= '0;
            extFlagQ <= 1'b0;
            brkFlagQ <= 1'b0;
            skipQ    <= '0;
            strbQ    <= 1'b0;
            errQ     <= 1'b0;
            makeQ    <= 1'b0;
            extQ     <= 1'b0;
            codeQ    <= '0;
        end else begin
            dSyncQ   <= {dSyncQ[0], ps2D};
            stateQ   <= stateD;
            bitCntQ  <= bitCntD;
            shiftQ   <= shiftD;
            parQ     <= parD;
            wdogQ    <= wdogD;
            extFlagQ <= extFlagD;
            brkFlagQ <= brkFlagD;
            skipQ    <= skipD;
            strbQ    <= strbD;
            errQ     <= errD;
            makeQ    <= makeD;
            extQ     <= extD;
            codeQ    <= codeD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        bitCntD  = bitCntQ;
        shiftD   = shiftQ;
        parD     = parQ;
        wdogD    = wdogQ;
        extFlagD = extFlagQ;
        brkFlagD = brkFlagQ;
        skipD    = skipQ;
        strbD    = 1'b0;
        errD     = 1'b0;
        makeD    = makeQ;
        extD     = extQ;
        codeD    = codeQ;

        if (stateQ == StIdle || ckFall) begin
            wdogD = '0;
        end else if (wdogQ == WdW'(TIMEOUT - 1)) begin
            errD     = 1'b1;
            stateD   = StIdle;
            wdogD    = '0;
            extFlagD = 1'b0;
            brkFlagD = 1'b0;
        end else begin
            wdogD = wdogQ + WdW'(1);
        end

        if (ckFall) begin
            unique case (stateQ)
                StIdle: begin
                    if (!dSync) begin
                        stateD  = StData;
                        bitCntD = '0;
                    end
                end
                StData: begin
                    shiftD  = {dSync, shiftQ[7:1]};
                    bitCntD = bitCntQ + 3'd1;
                    if (bitCntQ == 3'd7) stateD = StParity;
                end
                StParity: begin
                    parD   = dSync;
                    stateD = StStop;
                end
                StStop: begin
                    stateD = StIdle;
                    if (dSync && (^{shiftQ, parQ})) begin
                        // An E1 sequence swallows the following bytes whole.
                        if (skipQ != 3'd0) begin
                            skipD = skipQ - 3'd1;
                        end else if (shiftQ == ByteE0) begin
                            extFlagD = 1'b1;
                        end else if (shiftQ == ByteF0) begin
                            brkFlagD = 1'b1;
                        end else if (shiftQ == ByteE1) begin
                            skipD = 3'd7;
                        end else if (!isDropByte(shiftQ)) begin
                            strbD    = 1'b1;
                            codeD    = shiftQ;
                            makeD    = !brkFlagQ;
                            extD     = extFlagQ;
                            extFlagD = 1'b0;
                            brkFlagD = 1'b0;
                        end
                    end else begin
                        errD     = 1'b1;
                        extFlagD = 1'b0;
                        brkFlagD = 1'b0;
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    assign strb = strbQ;
    assign err  = errQ;
    assign make = makeQ;
    assign ext  = extQ;
    assign code = codeQ;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: directed vector table, hand-built
// timeout/reset sequences and randomized frames against a key-event model.
module tb_ps2_scan_decoder;

    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 300;
    localparam int HALF = 30;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2Ck = 1'b1;
    logic       ps2D  = 1'b1;
    logic       strb, make, ext, err;
    logic [7:0] code;

    ps2_scan_decoder #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ps2Ck (ps2Ck),
        .ps2D  (ps2D),
        .strb  (strb),
        .make  (make),
        .ext   (ext),
        .code  (code),
        .err   (err)
    );

    always #5 clock = ~clock;

    // Running totals of high cycles on the pulse outputs.
    int strbTot = 0;
    int errTot  = 0;
    always @(negedge clock) begin
        if (strb) strbTot++;
        if (err) errTot++;
    end

    int nCmp  = 0;
    int nFail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: keyboard prefix state and last reported key event.
    bit         mExt = 0, mBrk = 0;
    int         mSkip = 0;
    logic [7:0] mCode = 8'h00;
    bit         mMake = 0, mExtOut = 0;

    task automatic modelReset();
        mExt = 0; mBrk = 0; mSkip = 0;
        mCode = 8'h00; mMake = 0; mExtOut = 0;
    endtask

    task automatic modelByte(input logic [7:0] b, input bit good, output bit expS, output bit expE);
        expS = 0;
        expE = 0;
        if (!good) begin
            expE = 1; mExt = 0; mBrk = 0;
        end else if (mSkip > 0) begin
            mSkip--;
        end else if (b == 8'hE0) begin
            mExt = 1;
        end else if (b == 8'hF0) begin
            mBrk = 1;
        end else if (b == 8'hE1) begin
            mSkip = 7;
        end else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00}) begin
            // silently ignored
        end else begin
            expS = 1; mCode = b; mMake = !mBrk; mExtOut = mExt;
            mExt = 0; mBrk = 0;
        end
    endtask

    task automatic sendBit(input bit v, input bit glitch);
        ps2D = v;
        if (glitch) begin
            repeat (8) @(posedge clock);
            ps2Ck = 1'b0;
            repeat (2) @(posedge clock);
            ps2Ck = 1'b1;
            repeat (HALF - 10) @(posedge clock);
        end else begin
            repeat (HALF) @(posedge clock);
        end
        ps2Ck = 1'b0;
        if (glitch) begin
            repeat (8) @(posedge clock);
            ps2Ck = 1'b1;
            repeat (2) @(posedge clock);
            ps2Ck = 1'b0;
            repeat (HALF - 10) @(posedge clock);
        end else begin
            repeat (HALF) @(posedge clock);
        end
        ps2Ck = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop,
                             input bit glitch, input int nBits);
        logic [10:0] bits;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = (~^b) ^ badPar;
        bits[10]   = !badStop;
        for (int i = 0; i < nBits; i++) sendBit(bits[i], glitch);
        ps2D = 1'b1;
    endtask

    task automatic checkOutputs(input string nm, input int s0, input int e0, input bit expS,
                                input bit expE, input logic [7:0] expCode, input bit expMake,
                                input bit expExt);
        check({nm, " strb"}, 32'(strbTot - s0), {31'd0, expS});
        check({nm, " err"}, 32'(errTot - e0), {31'd0, expE});
        check({nm, " code"}, {24'd0, code}, {24'd0, expCode});
        check({nm, " make"}, {31'd0, make}, {31'd0, expMake});
        check({nm, " ext"}, {31'd0, ext}, {31'd0, expExt});
    endtask

    // Full frame checked against the model.
    task automatic modelFrame(input string nm, input logic [7:0] b, input bit badPar);
        int s0, e0;
        bit expS, expE;
        s0 = strbTot;
        e0 = errTot;
        sendFrame(b, badPar, 1'b0, 1'b0, 11);
        repeat (40) @(posedge clock);
        modelByte(b, !badPar, expS, expE);
        @(negedge clock);
        checkOutputs(nm, s0, e0, expS, expE, mCode, mMake, mExtOut);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         badPar;
        bit         badStop;
        bit         glitch;
        bit         expS;
        bit         expE;
        logic [7:0] expCode;
        bit         expMake;
        bit         expExt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit dS, dE;
        int s0, e0;

        vecs = '{
            '{8'h03, 0, 0, 0, 1, 0, 8'h03, 1, 0},
            '{8'hF0, 0, 0, 0, 0, 0, 8'h03, 1, 0},
            '{8'h01, 0, 0, 0, 1, 0, 8'h01, 0, 0},
            '{8'hE0, 0, 0, 0, 0, 0, 8'h01, 0, 0},
            '{8'hF0, 0, 0, 0, 0, 0, 8'h01, 0, 0},
            '{8'h75, 0, 0, 0, 1, 0, 8'h75, 0, 1},
            '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 1, 0},
            '{8'h03, 1, 0, 0, 0, 1, 8'h1C, 1, 0},
            '{8'h05, 0, 0, 0, 1, 0, 8'h05, 1, 0},
            '{8'hF0, 0, 0, 0, 0, 0, 8'h05, 1, 0},
            '{8'hE0, 0, 0, 0, 0, 0, 8'h05, 1, 0},
            '{8'hE0, 0, 0, 0, 0, 0, 8'h05, 1, 0},
            '{8'hF0, 0, 0, 0, 0, 0, 8'h05, 1, 0},
            '{8'h6B, 0, 0, 0, 1, 0, 8'h6B, 0, 1},
            '{8'hAA, 0, 0, 0, 0, 0, 8'h6B, 0, 1},
            '{8'hF0, 0, 0, 0, 0, 0, 8'h6B, 0, 1},
            '{8'hFA, 0, 0, 0, 0, 0, 8'h6B, 0, 1},
            '{8'h29, 0, 0, 0, 1, 0, 8'h29, 0, 0},
            '{8'h1C, 0, 0, 1, 1, 0, 8'h1C, 1, 0},
            '{8'h44, 0, 1, 0, 0, 1, 8'h1C, 1, 0},
            '{8'hE1, 0, 0, 0, 0, 0, 8'h1C, 1, 0},
            '{8'h14, 0, 0, 0, 0, 0, 8'h1C, 1, 0},
            '{8'h77, 0, 0, 0, 0, 0, 8'h1C, 1, 0},
            '{8'hE1, 0, 0, 0, 0, 0, 8'h1C, 1, 0},
            '{8'hF0, 0, 0, 0, 0, 0, 8'h1C, 1, 0},
            '{8'h14, 0, 0, 0, 0, 0, 8'h1C, 1, 0},
            '{8'hF0, 0, 0, 0, 0, 0, 8'h1C, 1, 0},
            '{8'h77, 0, 0, 0, 0, 0, 8'h1C, 1, 0},
            '{8'h03, 0, 0, 0, 1, 0, 8'h03, 1, 0},
            '{8'hE0, 0, 0, 0, 0, 0, 8'h03, 1, 0},
            '{8'h12, 1, 0, 0, 0, 1, 8'h03, 1, 0},
            '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 1, 0}
        };

        // Reset values.
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutputs("reset", strbTot, errTot, 0, 0, 8'h00, 0, 0);
        reset = 1'b1;
        modelReset();
        repeat (20) @(posedge clock);

        // Directed vector table; the model tracks along so later phases stay in step.
        foreach (vecs[i]) begin
            s0 = strbTot;
            e0 = errTot;
            sendFrame(vecs[i].data, vecs[i].badPar, vecs[i].badStop, vecs[i].glitch, 11);
            repeat (40) @(posedge clock);
            modelByte(vecs[i].data, !(vecs[i].badPar || vecs[i].badStop), dS, dE);
            @(negedge clock);
            checkOutputs($sformatf("vec%0d", i), s0, e0, vecs[i].expS, vecs[i].expE,
                         vecs[i].expCode, vecs[i].expMake, vecs[i].expExt);
        end

        // Stalled frame: watchdog must fire and clear the pending E0.
        modelFrame("pre-timeout E0", 8'hE0, 0);
        s0 = strbTot;
        e0 = errTot;
        sendFrame(8'h3A, 0, 0, 0, 4);
        repeat (TIMEOUT + 60) @(posedge clock);
        mExt = 0;
        mBrk = 0;
        @(negedge clock);
        checkOutputs("timeout", s0, e0, 0, 1, mCode, mMake, mExtOut);
        modelFrame("after timeout", 8'h01, 0);

        // Reset in the middle of a frame after an F0.
        modelFrame("pre-reset F0", 8'hF0, 0);
        sendFrame(8'h2B, 0, 0, 0, 5);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        modelReset();
        checkOutputs("mid-frame reset", strbTot, errTot, 0, 0, 8'h00, 0, 0);
        reset = 1'b1;
        s0 = strbTot;
        e0 = errTot;
        repeat (TIMEOUT + 60) @(posedge clock);
        @(negedge clock);
        checkOutputs("post-reset quiet", s0, e0, 0, 0, 8'h00, 0, 0);
        modelFrame("post-reset key", 8'h5A, 0);

        // Randomized bytes with occasional prefixes, drops and bad parity.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int r;
            r = int'($urandom_range(0, 15));
            case (r)
                0: b = 8'hE0;
                1, 2: b = 8'hF0;
                3: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hE0;
                4: b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'h00;
                default: b = 8'($urandom_range(0, 255));
            endcase
            modelFrame($sformatf("rand%0d", n), b, $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 SHALL have parameter FILTER, default 8, meaning consecutive identical samples needed to accept a ps2Ck level change.
REQ-002 SHALL have parameter TIMEOUT, default 4200, meaning clocks without a filtered falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clock, input, 1, system clock; the design has one clock.
REQ-004 SHALL have port reset, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port ps2Ck, input, 1, raw PS/2 keyboard clock, asynchronous.
REQ-006 SHALL have port ps2D, input, 1, raw PS/2 keyboard data, asynchronous.
REQ-007 SHALL have port strb, output, 1, one-clock pulse that marks a decoded key event.
REQ-008 SHALL have port make, output, 1, 1 for a press and 0 for a release; valid when strb is high.
REQ-009 SHALL have port ext, output, 1, 1 when the key had an E0 prefix; valid when strb is high.
REQ-010 SHALL have port code, output, 8, set-2 scancode with prefixes stripped; valid when strb is high.
REQ-011 SHALL have port err, output, 1, one-clock pulse on a framing, parity or timeout error.

Function
REQ-012 SHALL pass ps2Ck and ps2D through 2-flop synchronisers; the filtered clock starts at 1 and changes only after FILTER equal synchronised samples.
REQ-013 SHALL sample the synchronised ps2D on each filtered ps2Ck 1->0 edge.
REQ-014 SHALL use states IDLE, DATA, PARITY and STOP. IDLE->DATA on start bit 0 (start bit 1 is ignored). DATA->PARITY after 8 bits, LSB first. PARITY->STOP. STOP->IDLE.
REQ-015 SHALL accept a byte only when the stop bit is 1 and the data bits plus the parity bit have odd parity; otherwise it SHALL pulse err, discard the byte and clear all prefix flags.
REQ-016 SHALL run a watchdog counter outside IDLE that clears on every filtered falling edge; on reaching TIMEOUT it SHALL pulse err, return to IDLE and clear the prefix flags.
REQ-017 On an accepted E0 byte, SHALL set extFlag with no strobe.
REQ-018 On an accepted F0 byte, SHALL set brkFlag with no strobe.
REQ-019 On an accepted E1 byte, SHALL load a skip counter with 7; each following accepted byte decrements the counter and is dropped.
REQ-020 SHALL drop the bytes AA, FA, EE, FE and 00 silently and leave the flags unchanged.
REQ-021 For any other accepted byte, SHALL set code=byte, make=!brkFlag, ext=extFlag and pulse strb, then clear both flags.
REQ-022 Latency: strb or err SHALL be high for exactly 1 clock, beginning the clock after the filtered edge that samples the stop bit.
REQ-023 code, make and ext SHALL hold their values until the next strb.
REQ-024 If E0 and F0 arrive in either order, both flags SHALL apply to the next key byte.
REQ-025 A repeated E0 or F0 SHALL have no further effect.

Reset
REQ-026 On reset low, SHALL set state=IDLE, strb=0, err=0, make=0, ext=0, code=00, clear the flags, skip count, watchdog and filter counters, and force the filtered clock to 1.
REQ-027 A reset asserted mid-frame SHALL abandon the frame with no strobe after release; decoding SHALL resume at the next start bit.

Structure
REQ-028 SHALL take the state enum and the constants E0, F0, E1, AA, FA, EE and FE from shared package ps2_pkg.
REQ-029 SHALL place the synchroniser and glitch filter in sub-module ps2_glitch_filter (clock, reset, raw input, filtered level, fall pulse).
REQ-030 SHALL derive all counter widths from the parameters with $clog2.

Verification
REQ-031 Frame 0x03 with parity 1 -> one strb, make=1, ext=0, code=03.
REQ-032 F0 then 01 -> exactly one strb, make=0, code=01; no strobe for the F0 byte.
REQ-033 E0, F0, 75 -> strb with make=0, ext=1, code=75; the next plain 1C -> ext=0, make=1.
REQ-034 0x03 sent with wrong parity, then a valid 0x05 -> err pulse and no strb for the first byte; strb with code=05, make=1 for the second.
REQ-035 Frame halted after 4 bits for more than TIMEOUT clocks, then a full 0x01 -> err pulse, then strb with code=01.
REQ-036 2-clock glitch pulses on ps2Ck during a 0x1C frame with FILTER=8 -> strb with code=1C, no err; E1 followed by 7 bytes, then 0x03 -> a single strb with code=03.
